// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and fill FSM type for the PWConv frame path
package cnn_pkg;

  localparam int DATA_W     = 8;
  localparam int OUTPUT_NUM = 36;
  localparam int CH_NUM     = 32;

  // One channel strobe and one full frame, as packed widths
  localparam int CH_W       = OUTPUT_NUM * DATA_W;
  localparam int FRAME_W    = CH_NUM * CH_W;

  // Channel counter is wide enough to show CH_NUM; the slot index is not
  localparam int CNT_W      = $clog2(CH_NUM) + 1;
  localparam int IDX_W      = $clog2(CH_NUM);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fill_state_t;

endpackage

// File: rtl/pwconv_frame_bank.sv
// rtl/pwconv_frame_bank.sv - CH_NUM channel slots with indexed write and packed frame read
module pwconv_frame_bank
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [CH_W-1:0]    wr_data,
  output logic [FRAME_W-1:0] data
);

  logic [CH_W-1:0] slot [CH_NUM];

  // Slot storage: cleared on reset, one slot written per accepted strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        slot[i] <= '0;
      end
    end else if (wr_en) begin
      slot[wr_idx] <= wr_data;
    end
  end

  // Channel k lands in the k-th CH_W field of the packed frame
  for (genvar k = 0; k < CH_NUM; k++) begin : g_pack
    assign data[k*CH_W +: CH_W] = slot[k];
  end

endmodule

// File: rtl/pwconv_frame_collect.sv
// rtl/pwconv_frame_collect.sv - collects PWConv channel strobes into frames; PWCOLLECT_PINGPONG_EN selects two banks
module pwconv_frame_collect
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start_i,
  input  logic               ch_valid_i,
  input  logic [CH_W-1:0]    ch_pixel_i,
  output logic               frame_valid_o,
  input  logic               frame_ready_i,
  output logic [FRAME_W-1:0] frame_data_o,
  output logic [CNT_W-1:0]   ch_cnt_o,
  output logic [1:0]         err_o,
  input  logic               err_clr_i
);

  logic [CNT_W-1:0] ch_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       err;
  logic [1:0]       err_next;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             done;
  logic             fill_hold;
  logic             accept;

  assign accept = frame_valid_o && frame_ready_i;

  // Fill-side control: a frame start realigns to slot 0 before any same-cycle strobe is written
  always_comb begin
    wr_idx   = frame_start_i ? '0 : ch_cnt[IDX_W-1:0];
    wr_en    = ch_valid_i && !fill_hold;
    done     = wr_en && (wr_idx == IDX_W'(CH_NUM - 1));
    cnt_next = ch_cnt;
    if (wr_en) begin
      cnt_next = done ? '0 : CNT_W'(wr_idx) + CNT_W'(1);
    end else if (frame_start_i && !fill_hold) begin
      cnt_next = '0;
    end
    // Clear first so a same-cycle new error stays set
    err_next = err_clr_i ? 2'b00 : err;
    if (ch_valid_i && fill_hold) begin
      err_next[0] = 1'b1;
    end
    if (frame_start_i && !fill_hold && (ch_cnt != '0)) begin
      err_next[1] = 1'b1;
    end
  end

  // Channel counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt <= '0;
      err    <= '0;
    end else begin
      ch_cnt <= cnt_next;
      err    <= err_next;
    end
  end

  assign ch_cnt_o = ch_cnt;
  assign err_o    = err;

`ifdef PWCOLLECT_PINGPONG_EN

  fill_state_t      bank_state      [2];
  fill_state_t      bank_state_next [2];
  logic             fill_sel;
  logic             out_sel;
  logic [FRAME_W-1:0] bank_data     [2];

  // Banks complete and are accepted in the same alternating order, so both pointers just toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state[0] <= FILL;
      bank_state[1] <= FILL;
      fill_sel      <= 1'b0;
      out_sel       <= 1'b0;
    end else begin
      bank_state[0] <= bank_state_next[0];
      bank_state[1] <= bank_state_next[1];
      if (done) begin
        fill_sel <= ~fill_sel;
      end
      if (accept) begin
        out_sel <= ~out_sel;
      end
    end
  end

  // Per-bank next state: completion holds the fill bank, acceptance frees the presented bank
  always_comb begin
    bank_state_next[0] = bank_state[0];
    bank_state_next[1] = bank_state[1];
    for (int b = 0; b < 2; b++) begin
      if (done && (fill_sel == 1'(b))) begin
        bank_state_next[b] = HOLD;
      end
      if (accept && (out_sel == 1'(b))) begin
        bank_state_next[b] = FILL;
      end
    end
  end

  assign fill_hold     = (bank_state[fill_sel] == HOLD);
  assign frame_valid_o = (bank_state[out_sel] == HOLD);
  assign frame_data_o  = bank_data[out_sel];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pwconv_frame_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en && (fill_sel == 1'(b))),
      .wr_idx  (wr_idx),
      .wr_data (ch_pixel_i),
      .data    (bank_data[b])
    );
  end

`else

  fill_state_t state;
  fill_state_t state_next;

  // Single-bank fill/hold state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Hold after the last channel lands, fill again once the frame is taken
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (done)   state_next = HOLD;
      HOLD:    if (accept) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  assign fill_hold     = (state == HOLD);
  assign frame_valid_o = (state == HOLD);

  pwconv_frame_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (ch_pixel_i),
    .data    (frame_data_o)
  );

`endif

endmodule

// File: tb/tb_pwconv_frame_collect.sv
// tb/tb_pwconv_frame_collect.sv - self-checking bench for pwconv_frame_collect; honours PWCOLLECT_PINGPONG_EN
module tb_pwconv_frame_collect;
  import cnn_pkg::*;

`ifdef PWCOLLECT_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic               clk;
  logic               rst_n;
  logic               frame_start_i;
  logic               ch_valid_i;
  logic [CH_W-1:0]    ch_pixel_i;
  logic               frame_valid_o;
  logic               frame_ready_i;
  logic [FRAME_W-1:0] frame_data_o;
  logic [CNT_W-1:0]   ch_cnt_o;
  logic [1:0]         err_o;
  logic               err_clr_i;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of completed frames awaiting acceptance plus the partial frame
  logic [FRAME_W-1:0] mq [$];
  logic [FRAME_W-1:0] cur;
  int                 mcnt;
  logic [1:0]         merr;

  pwconv_frame_collect dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start_i),
    .ch_valid_i    (ch_valid_i),
    .ch_pixel_i    (ch_pixel_i),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .frame_data_o  (frame_data_o),
    .ch_cnt_o      (ch_cnt_o),
    .err_o         (err_o),
    .err_clr_i     (err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CH_W-1:0] bytes_of(input logic [7:0] b);
    return {OUTPUT_NUM{b}};
  endfunction

  function automatic logic [CH_W-1:0] rand_pix();
    logic [CH_W-1:0] r;
    for (int i = 0; i < CH_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int first_diff(input logic [FRAME_W-1:0] a, input logic [FRAME_W-1:0] b);
    for (int k = 0; k < CH_NUM; k++) begin
      if (a[k*CH_W +: CH_W] !== b[k*CH_W +: CH_W]) return k;
    end
    return 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic [CH_W-1:0] got, input logic [CH_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [FRAME_W-1:0] got, input logic [FRAME_W-1:0] exp);
    int k;
    checks++;
    assert (got === exp) else begin
      errors++;
      k = first_diff(got, exp);
      $error("FAIL %s: slot %0d got %h expected %h", tag, k, got[k*CH_W +: CH_W], exp[k*CH_W +: CH_W]);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur  = '0;
    mcnt = 0;
    merr = 2'b00;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [CH_W-1:0] p,
                            input logic r, input logic c);
    bit full;
    bit acc;
    full = (mq.size() == CAP);
    acc  = (mq.size() > 0) && r;
    if (c) merr = 2'b00;
    if (v && full) merr[0] = 1'b1;
    if (s && !full && mcnt != 0) merr[1] = 1'b1;
    if (s && !full) mcnt = 0;
    if (acc) mq.delete(0);
    if (v && !full) begin
      cur[mcnt*CH_W +: CH_W] = p;
      mcnt++;
      if (mcnt == CH_NUM) begin
        mq.push_back(cur);
        mcnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("valid", 32'(frame_valid_o), 32'(mq.size() > 0));
    check_val("ch_cnt", 32'(ch_cnt_o), 32'(mcnt));
    check_val("err", 32'(err_o), 32'(merr));
    if (mq.size() > 0) check_frame("data", frame_data_o, mq[0]);
  endtask

  task automatic step(input logic s, input logic v, input logic [CH_W-1:0] p,
                      input logic r, input logic c);
    frame_start_i = s;
    ch_valid_i    = v;
    ch_pixel_i    = p;
    frame_ready_i = r;
    err_clr_i     = c;
    @(posedge clk);
    model_step(s, v, p, r, c);
    #1;
    check_outputs();
    frame_start_i = 1'b0;
    ch_valid_i    = 1'b0;
    err_clr_i     = 1'b0;
  endtask

  task automatic strobe(input logic [CH_W-1:0] p, input logic r);
    step(1'b0, 1'b1, p, r, 1'b0);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, '0, r, 1'b0);
  endtask

  logic [FRAME_W-1:0] exp_frame;
  logic [CH_W-1:0]    d11;
  logic [CH_W-1:0]    pix;

  initial begin
    rst_n = 1'b0;
    frame_start_i = 1'b0;
    ch_valid_i = 1'b0;
    ch_pixel_i = '0;
    frame_ready_i = 1'b0;
    err_clr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(frame_valid_o), 32'd0);
    check_frame("rst_data", frame_data_o, '0);
    check_val("rst_cnt", 32'(ch_cnt_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;

    // 1: channel-index frame, ready high
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < CH_NUM; k++) begin
      exp_frame[k*CH_W +: CH_W] = bytes_of(8'(k));
      strobe(bytes_of(8'(k)), 1'b1);
    end
    check_val("t1_valid", 32'(frame_valid_o), 32'd1);
    check_frame("t1_frame", frame_data_o, exp_frame);
    check_val("t1_err", 32'(err_o), 32'd0);
    idle(1'b1);
    check_val("t1_pulse", 32'(frame_valid_o), 32'd0);

    // 2: hold for 50 cycles, then accept
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < CH_NUM; k++) strobe(rand_pix(), 1'b0);
    repeat (50) idle(1'b0);
    check_val("t2_held", 32'(frame_valid_o), 32'd1);
    idle(1'b1);
    check_val("t2_drop", 32'(frame_valid_o), 32'd0);

    // 3: partial frame aborted by a new start
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) strobe(rand_pix(), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    d11 = rand_pix();
    strobe(d11, 1'b0);
    for (int k = 1; k < CH_NUM; k++) strobe(rand_pix(), 1'b0);
    check_val("t3_err", 32'(err_o), 32'd2);
    check_slot("t3_slot0", frame_data_o[CH_W-1:0], d11);
    check_val("t3_cnt", 32'(ch_cnt_o), 32'd0);
    idle(1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_val("t3_clr", 32'(err_o), 32'd0);

    // 4: start coincident with a 0x7F strobe
    step(1'b1, 1'b1, bytes_of(8'h7F), 1'b0, 1'b0);
    check_val("t4_cnt", 32'(ch_cnt_o), 32'd1);
    for (int k = 1; k < CH_NUM; k++) strobe(rand_pix(), 1'b0);
    check_slot("t4_slot0", frame_data_o[CH_W-1:0], bytes_of(8'h7F));
    idle(1'b1);

    // 5: 33rd strobe while the frame is held
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < CH_NUM + 1; k++) strobe(rand_pix(), 1'b0);
    check_val("t5_drop", 32'(err_o[0]), 32'(CAP == 1));
    for (int k = 1; k < CH_NUM; k++) strobe(rand_pix(), 1'b0);
    idle(1'b1);
    check_val("t5_next", 32'(frame_valid_o), 32'(CAP == 2));
    repeat (3) idle(1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // 6: asynchronous reset at ch_cnt 20, then a clean frame
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) strobe(rand_pix(), 1'b0);
    check_val("t6_cnt20", 32'(ch_cnt_o), 32'd20);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("t6_valid", 32'(frame_valid_o), 32'd0);
    check_frame("t6_data", frame_data_o, '0);
    check_val("t6_cnt", 32'(ch_cnt_o), 32'd0);
    check_val("t6_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < CH_NUM; k++) begin
      pix = rand_pix();
      exp_frame[k*CH_W +: CH_W] = pix;
      strobe(pix, 1'b1);
    end
    check_frame("t6_frame", frame_data_o, exp_frame);
    idle(1'b1);

    // 7: randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 6), rand_pix(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
